// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - tick divider, button debounce/auto-repeat and RUN/SET mode control
// for the clock counter chain; all strobes are registered single-cycle pulses.
module clock_set_ctrl #(
    parameter int TICK_DIV      = 8000000,
    parameter int FAST_DIV      = 8000,
    parameter int DEB_CYCLES    = 160000,
    parameter int REPEAT_DELAY  = 4000000,
    parameter int REPEAT_PERIOD = 1600000,
    parameter int BLINK_DIV     = 4000000
) (
    input  logic       pCLK,
    input  logic       nRST,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       run_en,
    input  logic       fast_en,
    output logic       tick_1hz,
    output logic       min_inc,
    output logic       hour_inc,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blank_hour,
    output logic       blank_min
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    localparam logic [CW-1:0] TICK_LAST   = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] FAST_LAST   = CW'(FAST_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);

    localparam logic [1:0] S_RUN  = 2'b00;
    localparam logic [1:0] S_HOUR = 2'b01;
    localparam logic [1:0] S_MIN  = 2'b10;

    // bit order: 0 MODE, 1 INC, 2 run_en, 3 fast_en
    logic [3:0] sync1, sync2;

    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {fast_en, run_en, btn_inc, btn_mode};
            sync2 <= sync1;
        end
    end

    logic [1:0] deb, deb_d, rise;

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          lvl, lvl_d;

        always_ff @(posedge pCLK or negedge nRST) begin
            if (!nRST) begin
                cnt   <= '0;
                lvl   <= 1'b0;
                lvl_d <= 1'b0;
            end else begin
                lvl_d <= lvl;
                if (sync2[i] == lvl) begin
                    cnt <= '0;
                end else if (cnt == DEB_LAST) begin
                    lvl <= sync2[i];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign deb[i]   = lvl;
        assign deb_d[i] = lvl_d;
        assign rise[i]  = lvl & ~lvl_d;
    end

    // INC auto-repeat: first interval is the long delay, later ones the short period
    logic [RW-1:0] rep_cnt;
    logic          rep_first;
    logic [RW-1:0] rep_last;
    logic          inc_held, rep_hit;

    assign inc_held = deb[1] & deb_d[1];
    assign rep_last = rep_first ? DELAY_LAST : PERIOD_LAST;
    assign rep_hit  = inc_held & (rep_cnt == rep_last);

    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else if (rise[1]) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (inc_held) begin
            if (rep_hit) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

    logic       mode_press, inc_press;
    logic [1:0] state;
    logic       leave_set, enter_set;

    assign mode_press = rise[0];
    assign inc_press  = rise[1] | rep_hit;
    assign leave_set  = mode_press & (state == S_MIN);
    assign enter_set  = mode_press & ((state == S_RUN) | (state == S_HOUR));

    // Greater-or-equal so a switch to the fast divisor wraps at once
    logic [CW-1:0] div_cnt, div_last;
    logic          div_tick;

    assign div_last = sync2[3] ? FAST_LAST : TICK_LAST;
    assign div_tick = div_cnt >= div_last;

    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) begin
            div_cnt <= '0;
        end else if (div_tick | leave_set) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) begin
            state    <= S_RUN;
            tick_1hz <= 1'b0;
            hour_inc <= 1'b0;
            min_inc  <= 1'b0;
            sec_clr  <= 1'b0;
        end else begin
            tick_1hz <= div_tick & sync2[2] & (state == S_RUN);
            hour_inc <= ~mode_press & inc_press & (state == S_HOUR);
            min_inc  <= ~mode_press & inc_press & (state == S_MIN);
            sec_clr  <= leave_set;
            if (mode_press) begin
                case (state)
                    S_RUN:   state <= S_HOUR;
                    S_HOUR:  state <= S_MIN;
                    default: state <= S_RUN;
                endcase
            end
        end
    end

    logic [BW-1:0] blink_cnt;
    logic          phase;

    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (enter_set) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Digits stay lit while INC is held so the value is visible as it changes
    assign mode       = state;
    assign blank_hour = (state == S_HOUR) & phase & ~deb[1];
    assign blank_min  = (state == S_MIN) & phase & ~deb[1];

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - scoreboard bench for clock_set_ctrl against a cycle-level
// reference model, with directed scenarios followed by randomized button/switch activity.
module tb_clock_set_ctrl;

    localparam int TD = 10;
    localparam int FD = 2;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int BD = 6;

    logic       pCLK = 1'b0;
    logic       nRST = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       run_en = 1'b0;
    logic       fast_en = 1'b0;
    logic       tick_1hz, min_inc, hour_inc, sec_clr;
    logic [1:0] mode;
    logic       blank_hour, blank_min;

    always #5 pCLK = ~pCLK;

    clock_set_ctrl #(
        .TICK_DIV(TD), .FAST_DIV(FD), .DEB_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .BLINK_DIV(BD)
    ) dut (
        .pCLK(pCLK), .nRST(nRST), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .run_en(run_en), .fast_en(fast_en), .tick_1hz(tick_1hz), .min_inc(min_inc),
        .hour_inc(hour_inc), .sec_clr(sec_clr), .mode(mode),
        .blank_hour(blank_hour), .blank_min(blank_min)
    );

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int n_tick = 0, n_min = 0, n_hour = 0, n_sec = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model state: synced inputs, debounced levels, hold age, divider, blink, mode
    bit s1[4], s2[4];
    bit m_deb[2], m_prev[2];
    int m_run[2];
    int age, dcnt, bcnt, st;
    bit phase, o_tick, o_min, o_hour, o_sec;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin s1[i] = 0; s2[i] = 0; end
        for (int b = 0; b < 2; b++) begin m_deb[b] = 0; m_prev[b] = 0; m_run[b] = 0; end
        age = 0; dcnt = 0; bcnt = 0; st = 0; phase = 0;
        o_tick = 0; o_min = 0; o_hour = 0; o_sec = 0;
    endtask

    task automatic model_step();
        bit raw[4];
        bit rise[2];
        bit rep, modep, incp, dtick, bh, bm;
        int div;
        if (!nRST) begin
            model_reset();
        end else begin
            raw[0] = btn_mode; raw[1] = btn_inc; raw[2] = run_en; raw[3] = fast_en;
            for (int b = 0; b < 2; b++) rise[b] = m_deb[b] && !m_prev[b];
            // Repeat pulses fall at age RD, RD+RP, RD+2RP, ... edges after the first press
            rep = 0;
            if (m_deb[1] && m_prev[1]) begin
                age++;
                rep = (age == RD) || (age > RD && (age - RD) % RP == 0);
            end
            if (rise[1]) age = 0;
            modep = rise[0];
            incp  = rise[1] || rep;
            div   = s2[3] ? FD : TD;
            dtick = dcnt >= div - 1;
            o_tick = dtick && s2[2] && st == 0;
            o_hour = !modep && incp && st == 1;
            o_min  = !modep && incp && st == 2;
            o_sec  = modep && st == 2;
            dcnt = (dtick || o_sec) ? 0 : dcnt + 1;
            if (modep && st != 2) begin bcnt = 0; phase = 0; end
            else if (bcnt == BD - 1) begin bcnt = 0; phase = !phase; end
            else bcnt++;
            if (modep) st = (st + 1) % 3;
            for (int b = 0; b < 2; b++) begin
                m_prev[b] = m_deb[b];
                if (s2[b] == m_deb[b]) m_run[b] = 0;
                else begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin m_deb[b] = s2[b]; m_run[b] = 0; end
                end
            end
            for (int i = 0; i < 4; i++) begin s2[i] = s1[i]; s1[i] = raw[i]; end
        end
        bh = (st == 1) && phase && !m_deb[1];
        bm = (st == 2) && phase && !m_deb[1];
        exp_q.push_back({o_tick, o_min, o_hour, o_sec, st[1:0], bh, bm});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge pCLK);
            model_step();
        end
    end

    // Monitor: one expected vector per edge, compared half a cycle later
    initial begin
        logic [7:0] got, exp;
        @(posedge pCLK);
        forever begin
            @(negedge pCLK);
            cyc_n++;
            got = {tick_1hz, min_inc, hour_inc, sec_clr, mode, blank_hour, blank_min};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty cycle %0d got %0h", cyc_n, got);
            end else begin
                exp = exp_q.pop_front();
                if (!nRST) exp = '0;
                check($sformatf("cyc%0d strobes", cyc_n), 32'(got[7:4]), 32'(exp[7:4]));
                check($sformatf("cyc%0d mode_blank", cyc_n), 32'(got[3:0]), 32'(exp[3:0]));
            end
            n_tick += int'(tick_1hz);
            n_min  += int'(min_inc);
            n_hour += int'(hour_inc);
            n_sec  += int'(sec_clr);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge pCLK);
            #2;
        end
    endtask

    task automatic hold_btn(input logic m, input logic i, input int n);
        btn_mode = m;
        btn_inc  = i;
        cyc(n);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    initial begin
        #1000000;
        checks++;
        errors++;
        $display("FAIL watchdog cycle %0d", cyc_n);
        finish_run();
    end

    initial begin
        int c0, c1, sel;
        bit seen;
        cyc(3);
        nRST = 1'b1;
        run_en = 1'b1;

        c0 = n_tick; cyc(55);
        check("ticks_normal", n_tick - c0, 5);
        run_en = 1'b0;
        c0 = n_tick; cyc(30);
        check("ticks_run_off", n_tick - c0, 0);
        run_en = 1'b1;

        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge pCLK);
            if (tick_1hz) seen = 1;
        end
        check("tick_found", seen, 1);
        cyc(5);
        fast_en = 1'b1;
        c0 = n_tick; cyc(20);
        check("ticks_fast", n_tick - c0, 9);
        fast_en = 1'b0;
        cyc(5);

        hold_btn(1, 0, 3); cyc(12);
        check("bounce_mode", mode, 2'b00);
        hold_btn(1, 0, 8); cyc(12);
        check("mode_set_hour", mode, 2'b01);

        c0 = n_hour; hold_btn(0, 1, 40); cyc(15);
        check("hour_repeat", n_hour - c0, 5);

        hold_btn(1, 0, 8); cyc(12);
        check("mode_set_min", mode, 2'b10);
        c0 = n_min; hold_btn(0, 1, 8); cyc(12);
        check("min_single", n_min - c0, 1);
        c0 = n_sec; hold_btn(1, 0, 8); cyc(12);
        check("sec_clr_once", n_sec - c0, 1);
        check("mode_run", mode, 2'b00);
        cyc(15);

        hold_btn(1, 0, 8); cyc(40);
        hold_btn(0, 1, 10); cyc(12);

        c0 = n_hour; c1 = n_min;
        hold_btn(1, 1, 8); cyc(12);
        check("both_mode", mode, 2'b10);
        check("both_no_inc", (n_hour - c0) + (n_min - c1), 0);
        btn_inc = 1'b1;
        cyc(15);
        nRST = 1'b0;
        #1;
        check("rst_outputs", {tick_1hz, min_inc, hour_inc, sec_clr, mode, blank_hour, blank_min}, 0);
        cyc(2);
        btn_inc = 1'b0;
        cyc(1);
        nRST = 1'b1;
        cyc(5);
        check("rst_mode", mode, 2'b00);

        for (int it = 0; it < 60; it++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: hold_btn(1, 0, int'($urandom_range(1, 12)));
                3, 4, 5: hold_btn(0, 1, int'($urandom_range(1, 45)));
                6:       hold_btn(1, 1, int'($urandom_range(1, 12)));
                7:       run_en = 1'($urandom_range(0, 1));
                8:       fast_en = 1'($urandom_range(0, 1));
                default: begin
                    nRST = 1'b0;
                    cyc(2);
                    nRST = 1'b1;
                end
            endcase
            cyc(int'($urandom_range(0, 20)));
        end
        cyc(5);
        finish_run();
    end

endmodule
